lcd_responder: RTL and testbench

LCD_RESPONDER -- requirements
Module: lcd_responder

---
 rtl/lcd_responder.sv | 210 +++++++++++++++++++++
 tb/tb_lcd_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_responder.sv
// HD44780-style character LCD responder: decodes controller bus cycles, models DDRAM, AC and the busy flag.
// Define LCD_RESPONDER_READ_EN to enable bus reads (status and DDRAM); otherwise reads are ignored.
module lcd_responder #(
  parameter int BUSY_CYCLES  = 1850,
  parameter int CLEAR_CYCLES = 76000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       busy,
  output logic       wr_strobe,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_char,
  output logic       err_busy
);

  localparam int MAXC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE, FILL, WAIT} state_t;

  state_t          state, next_state;
  logic [CW-1:0]   cnt, cnt_d;
  logic [4:0]      idx, idx_d;
  logic            fill_wait;

  logic [10:0]     bus_p0, bus_p1;
  logic            e_s, rw_s, rs_s;
  logic [7:0]      data_s;
  logic            e_prev, rs_l, rw_l;
  logic [7:0]      data_l;
  logic [6:0]      ac;
  logic            id;

  logic e_fall, acc, acc_wr, acc_cmd, acc_data, acc_rd, rej, cmd_clear, cmd_home;

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == 7'h0F)      ac_step = 7'h40;
      else if (a == 7'h4F) ac_step = 7'h00;
      else                 ac_step = a + 7'd1;
    end else begin
      if (a == 7'h40)      ac_step = 7'h0F;
      else if (a == 7'h00) ac_step = 7'h4F;
      else                 ac_step = a - 7'd1;
    end
  endfunction

  function automatic logic [6:0] ac_load(input logic [6:0] a);
    if (a[5:4] == 2'b00) ac_load = a;
    else                 ac_load = a[6] ? 7'h40 : 7'h00;
  endfunction

  // Stage p0/p1: two-flop synchronizer for the asynchronous bus
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_p0 <= '0;
      bus_p1 <= '0;
      e_prev <= 1'b0;
      rs_l   <= 1'b0;
      rw_l   <= 1'b0;
      data_l <= '0;
    end else begin
      bus_p0 <= {lcd_e, lcd_rw, lcd_rs, lcd_data_in};
      bus_p1 <= bus_p0;
      e_prev <= e_s;
      if (e_s) begin
        rs_l   <= rs_s;
        rw_l   <= rw_s;
        data_l <= data_s;
      end
    end
  end

  assign {e_s, rw_s, rs_s, data_s} = bus_p1;

  assign busy      = (state != IDLE);
  assign e_fall    = e_prev & ~e_s;
  assign acc       = e_fall & ~busy;
  assign acc_wr    = acc & ~rw_l;
  assign acc_cmd   = acc_wr & ~rs_l;
  assign acc_data  = acc_wr & rs_l;
  assign cmd_clear = (data_l == 8'h01);
  assign cmd_home  = (data_l[7:1] == 7'h01);
`ifdef LCD_RESPONDER_READ_EN
  assign acc_rd = acc & rw_l & rs_l;
  assign rej    = e_fall & busy & (~rw_l | rs_l);
`else
  assign acc_rd = 1'b0;
  assign rej    = e_fall & busy & ~rw_l;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= next_state;
      idx   <= idx_d;
      cnt   <= cnt_d;
    end
  end

  // Fill cycles are part of the clear busy time, so WAIT only covers the remainder
  always_comb begin
    next_state = state;
    cnt_d      = cnt;
    idx_d      = idx;
    case (state)
      IDLE: begin
        if (acc_cmd && cmd_clear) begin
          next_state = FILL;
          idx_d      = '0;
        end else if (acc_wr) begin
          next_state = WAIT;
          cnt_d      = (acc_cmd && cmd_home) ? CW'(CLEAR_CYCLES - 1) : CW'(BUSY_CYCLES - 1);
        end
      end
      FILL: begin
        idx_d = idx + 5'd1;
        if (idx == 5'd31) begin
          if (fill_wait && (CLEAR_CYCLES > 32)) begin
            next_state = WAIT;
            cnt_d      = CW'(CLEAR_CYCLES - 33);
          end else begin
            next_state = IDLE;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) next_state = IDLE;
        else           cnt_d = cnt - CW'(1);
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ac         <= 7'h00;
      id         <= 1'b1;
      display_on <= 1'b0;
      cursor_on  <= 1'b0;
      blink_on   <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_addr    <= 7'h00;
      wr_char    <= 8'h00;
      err_busy   <= 1'b0;
      fill_wait  <= 1'b0;
    end else begin
      wr_strobe <= acc_data;
      err_busy  <= rej;
      if (acc_cmd) begin
        if (data_l[7])              ac <= ac_load(data_l[6:0]);
        else if (data_l[6:4] != '0) ;
        else if (data_l[3]) begin
          display_on <= data_l[2];
          cursor_on  <= data_l[1];
          blink_on   <= data_l[0];
        end
        else if (data_l[2])         id <= data_l[1];
        else if (data_l[1])         ac <= 7'h00;
        else if (data_l[0]) begin
          ac        <= 7'h00;
          id        <= 1'b1;
          fill_wait <= 1'b1;
        end
      end
      if (acc_data) begin
        wr_addr <= ac;
        wr_char <= data_l;
        ac      <= ac_step(ac, id);
      end
      if (acc_rd) ac <= ac_step(ac, id);
    end
  end

`ifdef LCD_RESPONDER_READ_EN
  // DDRAM contents are only observable through reads, so storage exists only in this build
  logic [7:0] ddram [32];
  logic [7:0] live, hold;

  always_ff @(posedge clk) begin
    if (state == FILL)  ddram[idx] <= 8'h20;
    else if (acc_data)  ddram[{ac[6], ac[3:0]}] <= data_l;
  end

  assign live         = rs_s ? ddram[{ac[6], ac[3:0]}] : {busy, ac};
  assign lcd_data_oe  = e_s & rw_s;
  assign lcd_data_out = lcd_data_oe ? live : hold;

  always_ff @(posedge clk) begin
    if (rst)              hold <= 8'h00;
    else if (lcd_data_oe) hold <= live;
  end
`else
  assign lcd_data_oe  = 1'b0;
  assign lcd_data_out = 8'h00;
`endif

endmodule

// File: tb/tb_lcd_responder.sv
// Directed self-checking bench for lcd_responder (short busy times for fast runs).
module tb_lcd_responder;
  localparam int BC = 40;
  localparam int CC = 100;

  logic       clk = 1'b0;
  logic       rst, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_data_in, lcd_data_out, wr_char;
  logic       lcd_data_oe, display_on, cursor_on, blink_on, busy, wr_strobe, err_busy;
  logic [6:0] wr_addr;

  int vectors = 0, fails = 0;
  int strobe_cnt = 0, err_cnt = 0, busy_run = 0, last_run = 0;
  int s0, e0;
  logic       oe;
  logic [7:0] q;

  always #5 clk = ~clk;

  lcd_responder #(.BUSY_CYCLES(BC), .CLEAR_CYCLES(CC)) dut (
    .clk(clk), .rst(rst), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_data_in(lcd_data_in), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe),
    .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on), .busy(busy),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_char(wr_char), .err_busy(err_busy)
  );

  // Pulse counters and busy-length measurement
  always @(negedge clk) begin
    if (wr_strobe) strobe_cnt++;
    if (err_busy) err_cnt++;
    if (rst) busy_run = 0;
    else if (busy) busy_run++;
    else if (busy_run != 0) begin
      last_run = busy_run;
      busy_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic bus_write(input logic rs, input logic [7:0] d);
    lcd_rs = rs; lcd_rw = 1'b0; lcd_data_in = d; lcd_e = 1'b1;
    tick(3);
    lcd_e = 1'b0;
    tick(4);
  endtask

  task automatic bus_read(input logic rs, output logic o, output logic [7:0] v);
    lcd_rs = rs; lcd_rw = 1'b1; lcd_e = 1'b1;
    tick(3);
    @(negedge clk);
    o = lcd_data_oe;
    v = lcd_data_out;
    lcd_e = 1'b0;
    tick(4);
    lcd_rw = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 2 * CC + 200) begin
      tick(1);
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
    tick(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_oe"}, 32'(lcd_data_oe), 32'd0);
    check({tag, "_dout"}, 32'(lcd_data_out), 32'h00);
    check({tag, "_strobe"}, 32'(wr_strobe), 32'd0);
    check({tag, "_waddr"}, 32'(wr_addr), 32'h00);
    check({tag, "_wchar"}, 32'(wr_char), 32'h00);
    check({tag, "_err"}, 32'(err_busy), 32'd0);
    check({tag, "_disp"}, 32'(display_on), 32'd0);
    check({tag, "_cur"}, 32'(cursor_on), 32'd0);
    check({tag, "_blink"}, 32'(blink_on), 32'd0);
  endtask

  initial begin
    rst = 1'b1; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_e = 1'b0; lcd_data_in = 8'h00;
    tick(4);
    check_reset_outputs("rst");
    rst = 1'b0;
    wait_idle("por");
    check("por_busy_len", 32'(last_run), 32'd32);

`ifdef LCD_RESPONDER_READ_EN
    bus_read(1'b0, oe, q);
    check("por_status_oe", 32'(oe), 32'd1);
    check("por_status", 32'(q), 32'h00);
    for (int i = 0; i < 32; i++) begin
      bus_read(1'b1, oe, q);
      check("por_ddram", 32'(q), 32'h20);
    end
    check("oe_released", 32'(lcd_data_oe), 32'd0);
`else
    bus_read(1'b0, oe, q);
    check("noread_oe", 32'(oe), 32'd0);
    check("noread_dout", 32'(q), 32'h00);
`endif

    // Set AC=0 then write 'A'
    bus_write(1'b0, 8'h80);
    wait_idle("cmd80");
    check("cmd80_busy_len", 32'(last_run), 32'(BC));
    s0 = strobe_cnt;
    bus_write(1'b1, 8'h41);
    check("data41_strobe", 32'(strobe_cnt), 32'(s0 + 1));
    check("data41_addr", 32'(wr_addr), 32'h00);
    check("data41_char", 32'(wr_char), 32'h41);
    wait_idle("data41");
    check("data41_busy_len", 32'(last_run), 32'(BC));
`ifdef LCD_RESPONDER_READ_EN
    bus_read(1'b0, oe, q);
    check("status_after_41", 32'(q), 32'h01);
`endif

    // Increment wraps 0x4F -> 0x00
    bus_write(1'b0, 8'hCF); wait_idle("set4f");
    bus_write(1'b1, 8'h42);
    check("wrap_inc_a", 32'(wr_addr), 32'h4F);
    wait_idle("d42");
    bus_write(1'b1, 8'h43);
    check("wrap_inc_b", 32'(wr_addr), 32'h00);
    wait_idle("d43");

    // Decrement wraps 0x40 -> 0x0F
    bus_write(1'b0, 8'h04); wait_idle("dec");
    bus_write(1'b0, 8'hC0); wait_idle("set40");
    bus_write(1'b1, 8'h44);
    check("wrap_dec_a", 32'(wr_addr), 32'h40);
    wait_idle("d44");
    bus_write(1'b1, 8'h45);
    check("wrap_dec_b", 32'(wr_addr), 32'h0F);
    wait_idle("d45");
    bus_write(1'b0, 8'h06); wait_idle("inc");

    // Invalid address 0x57 loads 0x40
    bus_write(1'b0, 8'hD7); wait_idle("set57");
    bus_write(1'b1, 8'h46);
    check("bad_addr", 32'(wr_addr), 32'h40);
    wait_idle("d46");

    // Accesses while busy are dropped
    e0 = err_cnt;
    bus_write(1'b0, 8'h0D);
    bus_write(1'b0, 8'h01);
    bus_read(1'b1, oe, q);
`ifdef LCD_RESPONDER_READ_EN
    check("busy_rejects", 32'(err_cnt), 32'(e0 + 2));
`else
    check("busy_rejects", 32'(err_cnt), 32'(e0 + 1));
`endif
    check("ctl_disp", 32'(display_on), 32'd1);
    check("ctl_cur", 32'(cursor_on), 32'd0);
    check("ctl_blink", 32'(blink_on), 32'd1);
    wait_idle("ctl");
    check("ctl_busy_len", 32'(last_run), 32'(BC));
    bus_write(1'b1, 8'h47);
    check("ac_kept", 32'(wr_addr), 32'h41);
    wait_idle("d47");

    // Return home
    bus_write(1'b0, 8'h02);
    wait_idle("home");
    check("home_busy_len", 32'(last_run), 32'(CC));
    bus_write(1'b1, 8'h48);
    check("home_ac", 32'(wr_addr), 32'h00);
    wait_idle("d48");

    // Clear restores I/D=1 and AC=0
    bus_write(1'b0, 8'h04); wait_idle("dec2");
    s0 = strobe_cnt;
    bus_write(1'b0, 8'h01);
    wait_idle("clear");
    check("clear_busy_len", 32'(last_run), 32'(CC));
    check("clear_no_strobe", 32'(strobe_cnt), 32'(s0));
`ifdef LCD_RESPONDER_READ_EN
    for (int i = 0; i < 32; i++) begin
      bus_read(1'b1, oe, q);
      check("clear_ddram", 32'(q), 32'h20);
    end
`endif
    bus_write(1'b1, 8'h49);
    check("clear_ac", 32'(wr_addr), 32'h00);
    wait_idle("d49");
    bus_write(1'b1, 8'h4A);
    check("clear_id", 32'(wr_addr), 32'h01);
    wait_idle("d4a");

    // Reset in the middle of a clear
    bus_write(1'b0, 8'h04); wait_idle("dec3");
    bus_write(1'b0, 8'h01);
    tick(9);
    rst = 1'b1;
    tick(1);
    check_reset_outputs("midrst");
    rst = 1'b0;
    wait_idle("midrst_fill");
    check("midrst_busy_len", 32'(last_run), 32'd32);
    bus_write(1'b1, 8'h4B);
    check("midrst_ac", 32'(wr_addr), 32'h00);
    wait_idle("d4b");
    bus_write(1'b1, 8'h4C);
    check("midrst_id", 32'(wr_addr), 32'h01);
    wait_idle("d4c");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
